pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning number of register stages; DATA_WIDTH % STAGES == 0 is required; CHUNK = DATA_WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port a, input, DATA_WIDTH, first operand.
REQ-006 SHALL have port b, input, DATA_WIDTH, second operand.
REQ-007 SHALL have port ci, input, 1, carry in.
REQ-008 SHALL have port in_vld, input, 1, operands valid.
REQ-009 SHALL have port in_rd, output, 1, block can accept operands.
REQ-010 SHALL have port s, output, DATA_WIDTH, sum.
REQ-011 SHALL have port co, output, 1, carry out of bit DATA_WIDTH-1.
REQ-012 SHALL have port out_vld, output, 1, s/co valid.
REQ-013 SHALL have port out_rd, input, 1, consumer accepts result.

Function
REQ-014 SHALL compute {co, s} = a + b + ci modulo 2^(DATA_WIDTH+1), exact for all inputs.
REQ-015 SHALL split the add into STAGES chunks of CHUNK bits; stage k adds chunk k (bits k*CHUNK..(k+1)*CHUNK-1) using the carry registered by stage k-1 (stage 0 uses ci).
REQ-016 SHALL register in stage k: valid bit, carry, completed sum chunks 0..k, unconsumed operand chunks k+1..STAGES-1.
REQ-017 SHALL transfer input on a cycle with in_vld && in_rd; transfer output on a cycle with out_vld && out_rd.
REQ-018 SHALL load stage k when stage k is empty or stage k itself advances on that cycle (next stage loads, or for last stage out_rd=1).
REQ-019 SHALL drive in_rd = stage 0 loads on this cycle; in_rd may depend combinationally on out_rd.
REQ-020 SHALL give latency STAGES cycles from input transfer to out_vld with no backpressure; throughput one result per cycle.
REQ-021 SHALL drive out_vld, s, co directly from the last stage registers (no combinational path from a/b to s).
REQ-022 SHALL hold s, co stable while out_vld=1 and out_rd=0; no result dropped or duplicated.
REQ-023 SHALL let a bubble (empty stage) be filled while downstream stalls, so a full pipeline holds STAGES results.
REQ-024 SHALL with STAGES=1 behave as a single registered adder with a one-entry skid-free output register.
REQ-025 SHALL ignore a, b, ci when in_vld=0 or in_rd=0.

Reset
REQ-026 SHALL on rst=1 immediately clear all stage valid bits; out_vld=0, s=0, co=0 asynchronously.
REQ-027 SHALL discard in-flight results on reset mid-operation; in_rd=1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL with macro PIPELINED_ADDER_OVF_EN defined add output ovf (1 bit), set with out_vld when signed two's-complement overflow occurred (carry into MSB != carry out of MSB), 0 at reset.
REQ-029 SHALL without PIPELINED_ADDER_OVF_EN have no ovf port and no extra state.

Verification (DATA_WIDTH=8, STAGES=4)
REQ-030 SHALL test carry ripple across all chunks: a=0xFF, b=0x01, ci=0, out_rd=1 -> after 4 cycles out_vld=1, s=0x00, co=1.
REQ-031 SHALL test back-to-back stream: a=i, b=2*i, ci=i[0] for i=0..15 each cycle, out_rd=1 -> 16 consecutive results s=3*i+i[0] (mod 256), no gaps.
REQ-032 SHALL test backpressure: out_rd=0 for 10 cycles while in_vld=1 -> in_rd drops after 4 accepted; out_rd=1 -> 4 results in order, unchanged values.
REQ-033 SHALL test reset mid-flight: 3 operations accepted, rst pulsed -> out_vld=0, s=0, no old result emitted afterwards.
REQ-034 SHALL test overflow (macro on): a=0x7F, b=0x01 -> s=0x80, co=0, ovf=1; a=0xFF, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// Carries ovf only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] a, b, s;
    logic ci, in_vld, in_rd, co, out_vld, out_rd;
`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf;
    modport master(output a, b, ci, in_vld, out_rd, input in_rd, s, co, out_vld, ovf);
    modport slave(input a, b, ci, in_vld, out_rd, output in_rd, s, co, out_vld, ovf);
`else
    modport master(output a, b, ci, in_vld, out_rd, input in_rd, s, co, out_vld);
    modport slave(input a, b, ci, in_vld, out_rd, output in_rd, s, co, out_vld);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked ripple adder with valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = DATA_WIDTH / STAGES;
    localparam int L = STAGES - 1;
    // x holds completed sum chunks below the stage's chunk and untouched a chunks above it
    logic [STAGES-1:0][DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, xp, yp;
    logic [STAGES-1:0] v_q, v_d, c_q, c_d, cp, ld;
    logic [CHUNK:0] t;
    logic nxt;
`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif
    always_comb begin
        ld = '0;
        nxt = bus.out_rd;
        for (int k = L; k >= 0; k--) begin
            ld[k] = !v_q[k] || nxt;
            nxt = ld[k];
        end
        xp = '0;
        yp = '0;
        v_d = '0;
        cp = '0;
        xp[0] = bus.a;
        yp[0] = bus.b;
        v_d[0] = bus.in_vld;
        cp[0] = bus.ci;
        for (int k = 1; k < STAGES; k++) begin
            xp[k] = x_q[k-1];
            yp[k] = y_q[k-1];
            v_d[k] = v_q[k-1];
            cp[k] = c_q[k-1];
        end
        t = '0;
        x_d = '0;
        y_d = '0;
        c_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, xp[k][k*CHUNK +: CHUNK]} + {1'b0, yp[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, cp[k]};
            x_d[k] = xp[k];
            x_d[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
            y_d[k] = yp[k];
            c_d[k] = t[CHUNK];
        end
`ifdef PIPELINED_ADDER_OVF_EN
        ovf_d = t[CHUNK] ^ xp[L][DATA_WIDTH-1] ^ yp[L][DATA_WIDTH-1] ^ t[CHUNK-1];
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            x_q <= '0;
            y_q <= '0;
`ifdef PIPELINED_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_d[k];
                    if (v_d[k]) begin
                        x_q[k] <= x_d[k];
                        y_q[k] <= y_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
`ifdef PIPELINED_ADDER_OVF_EN
            if (ld[L] && v_d[L]) ovf_q <= ovf_d;
`endif
        end
    end
    assign bus.in_rd = ld[0];
    assign bus.s = x_q[L];
    assign bus.co = c_q[L];
    assign bus.out_vld = v_q[L];
`ifdef PIPELINED_ADDER_OVF_EN
    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder at DATA_WIDTH=8, STAGES=4.
// Honours PIPELINED_ADDER_OVF_EN for the overflow scenario.
module tb_pipelined_adder;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];

    pipelined_adder_if #(.DATA_WIDTH(8)) bus();
    pipelined_adder #(.DATA_WIDTH(8), .STAGES(4)) dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        t = {1'b0, x} + {1'b0, y} + {8'h00, c};
        return {(x[7] == y[7]) && (t[7] != x[7]), t};
    endfunction

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c, input logic v, input logic r);
        @(negedge clk);
        bus.a = x;
        bus.b = y;
        bus.ci = c;
        bus.in_vld = v;
        bus.out_rd = r;
        #1;
        if (v && bus.in_rd) q.push_back(model(x, y, c));
    endtask

    task automatic test_reset;
        bus.a = 0;
        bus.b = 0;
        bus.ci = 0;
        bus.in_vld = 0;
        bus.out_rd = 0;
        rst = 1;
        #12;
        checks++;
        if ({bus.out_vld, bus.co, bus.s} !== 10'h000) begin
            errors++;
            $display("FAIL reset_state: got out_vld=%b co=%b s=%h, expected 0 0 00", bus.out_vld, bus.co, bus.s);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, expected 0", bus.ovf);
        end
`endif
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (bus.in_rd !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rd: got %b, expected 1", bus.in_rd);
        end
    endtask

    task automatic test_carry;
        int lat = -1;
        logic [9:0] e;
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            if (bus.out_vld) begin
                lat = n;
                e = (q.size() > 0) ? q.pop_front() : 'x;
                checks++;
                if ({bus.co, bus.s} !== e[8:0] || {bus.co, bus.s} !== 9'h100) begin
                    errors++;
                    $display("FAIL carry_ripple: got co=%b s=%h, expected co=1 s=00", bus.co, bus.s);
                end
            end
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL carry_latency: got %0d cycles, expected 4", lat);
        end
    endtask

    task automatic test_back_to_back;
        int pops = 0;
        int first = -1;
        int last = -1;
        logic [9:0] e;
        for (int n = 0; n < 40 && pops < 16; n++) begin
            if (n < 16) begin
                drive(8'(n), 8'(2 * n), 1'(n & 1), 1'b1, 1'b1);
                checks++;
                if (bus.in_rd !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_rd: cycle %0d got %b, expected 1", n, bus.in_rd);
                end
            end else drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            if (bus.out_vld) begin
                e = (q.size() > 0) ? q.pop_front() : 'x;
                checks++;
                if ({bus.co, bus.s} !== e[8:0]) begin
                    errors++;
                    $display("FAIL b2b_result: got co=%b s=%h, expected co=%b s=%h", bus.co, bus.s, e[8], e[7:0]);
                end
                pops++;
                if (first < 0) first = n;
                last = n;
            end
        end
        checks++;
        if (pops != 16 || last - first != 15) begin
            errors++;
            $display("FAIL b2b_gaps: got %0d results over %0d cycles, expected 16 over 16", pops, last - first + 1);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] held = 0;
        logic seen = 0;
        int pops = 0;
        logic [9:0] e;
        for (int n = 0; n < 10; n++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
            if (bus.out_vld) begin
                if (!seen) begin
                    seen = 1;
                    held = bus.s;
                end else begin
                    checks++;
                    if (bus.s !== held) begin
                        errors++;
                        $display("FAIL bp_hold: got s=%h, expected %h", bus.s, held);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 4 || !seen) begin
            errors++;
            $display("FAIL bp_accepted: got %0d (out_vld seen %b), expected 4 (1)", q.size(), seen);
        end
        checks++;
        if (bus.in_rd !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_rd: got %b, expected 0", bus.in_rd);
        end
        for (int n = 0; n < 10 && pops < 4; n++) begin
            drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            if (bus.out_vld) begin
                e = (q.size() > 0) ? q.pop_front() : 'x;
                checks++;
                if ({bus.co, bus.s} !== e[8:0]) begin
                    errors++;
                    $display("FAIL bp_result: got co=%b s=%h, expected co=%b s=%h", bus.co, bus.s, e[8], e[7:0]);
                end
                pops++;
            end
        end
        checks++;
        if (pops != 4) begin
            errors++;
            $display("FAIL bp_drain: got %0d results, expected 4", pops);
        end
    endtask

    task automatic test_reset_mid;
        for (int n = 0; n < 3; n++) drive(8'(n + 16), 8'h01, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_vld !== 1'b1 || bus.s !== 8'h11) begin
            errors++;
            $display("FAIL rstmid_pre: got out_vld=%b s=%h, expected 1 11", bus.out_vld, bus.s);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({bus.out_vld, bus.co, bus.s} !== 10'h000) begin
            errors++;
            $display("FAIL rstmid_clear: got out_vld=%b co=%b s=%h, expected 0 0 00", bus.out_vld, bus.co, bus.s);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (bus.in_rd !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_rd: got %b, expected 1", bus.in_rd);
        end
        q.delete();
        for (int n = 0; n < 10; n++) begin
            drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.out_vld !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale: got out_vld=%b s=%h, expected out_vld 0", bus.out_vld, bus.s);
            end
        end
    endtask

`ifdef PIPELINED_ADDER_OVF_EN
    task automatic test_ovf;
        int pops = 0;
        logic [9:0] e;
        drive(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 10 && pops < 2; n++) begin
            drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            if (bus.out_vld) begin
                e = (q.size() > 0) ? q.pop_front() : 'x;
                checks++;
                if ({bus.ovf, bus.co, bus.s} !== e || bus.ovf !== (pops == 0)) begin
                    errors++;
                    $display("FAIL ovf_result: got ovf=%b co=%b s=%h, expected ovf=%b co=%b s=%h", bus.ovf, bus.co, bus.s, e[9], e[8], e[7:0]);
                end
                pops++;
            end
        end
        checks++;
        if (pops != 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d results, expected 2", pops);
        end
    endtask
`endif

    task automatic test_random;
        logic [9:0] e;
        for (int n = 0; n < 260 && (n < 200 || q.size() > 0); n++) begin
            if (n < 200) drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            else drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            if (bus.out_vld && bus.out_rd) begin
                e = (q.size() > 0) ? q.pop_front() : 'x;
                checks++;
                if ({bus.co, bus.s} !== e[8:0]) begin
                    errors++;
                    $display("FAIL rand_result: got co=%b s=%h, expected co=%b s=%h", bus.co, bus.s, e[8], e[7:0]);
                end
`ifdef PIPELINED_ADDER_OVF_EN
                checks++;
                if (bus.ovf !== e[9]) begin
                    errors++;
                    $display("FAIL rand_ovf: got %b, expected %b", bus.ovf, e[9]);
                end
`endif
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_leftover: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef PIPELINED_ADDER_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
